keypad_scanner: RTL and testbench

//  Scans the physical 4x3 matrix keypad and produces the one-hot row/col key code that elock_init consumes.

---
 rtl/elock_pkg.sv | 41 ++++
 rtl/elock_sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elock_pkg.sv
// Shared keypad definitions: matrix geometry, special key codes, debounce
// FSM encoding and the (row,col) -> key code mapping.
package elock_pkg;

  localparam int NROW = 4;
  localparam int NCOL = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  localparam logic ST_RELEASED_ENC = 1'b0;
  localparam logic ST_PRESSED_ENC  = 1'b1;

  typedef enum logic {
    ST_RELEASED = ST_RELEASED_ENC,
    ST_PRESSED  = ST_PRESSED_ENC
  } kp_state_e;

  // Row [3] is the top row (1,2,3); col [2] is the left column.
  function automatic logic [3:0] kp_encode(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] code;
    case ({row, col})
      7'b1000_100: code = 4'd1;
      7'b1000_010: code = 4'd2;
      7'b1000_001: code = 4'd3;
      7'b0100_100: code = 4'd4;
      7'b0100_010: code = 4'd5;
      7'b0100_001: code = 4'd6;
      7'b0010_100: code = 4'd7;
      7'b0010_010: code = 4'd8;
      7'b0010_001: code = 4'd9;
      7'b0001_100: code = KEY_STAR;
      7'b0001_010: code = 4'd0;
      7'b0001_001: code = KEY_HASH;
      default:     code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/elock_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on
// synchronous reset.
module elock_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Strobes a 4x3 matrix keypad one row at a time, debounces whole-scan results
// and presents a one-hot row/col key with a single-cycle press strobe.
module keypad_scanner
  import elock_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] kp_row_drv,
  input  logic [2:0] kp_col_sense,
  output logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_pulse
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_SCANS);

  logic [2:0]                  col_sync_s;
  logic                        dwell_last_s;
  logic                        scan_done_s;
  logic [NROW-1:0][NCOL-1:0]   scan_s;
  logic                        single_s;
  logic [3:0]                  srow_s;
  logic [2:0]                  scol_s;
  logic                        same_key_s;
  logic [DW-1:0]               deb_inc_s;
  logic [DW-1:0]               deb_next_s;

  logic [CW-1:0]               dwell_q, dwell_d;
  logic [1:0]                  ridx_q, ridx_d;
  logic [3:0]                  row_drv_q, row_drv_d;
  logic [NROW-1:0][NCOL-1:0]   acc_q, acc_d;
  kp_state_e                   state_q, state_d;
  logic [DW-1:0]               deb_q, deb_d;
  logic                        prev_valid_q, prev_valid_d;
  logic [3:0]                  prev_row_q, prev_row_d;
  logic [2:0]                  prev_col_q, prev_col_d;
  logic [3:0]                  row_q, row_d;
  logic [2:0]                  col_q, col_d;
  logic                        valid_q, valid_d;
  logic [3:0]                  code_q, code_d;
  logic                        pulse_q, pulse_d;

  elock_sync2 #(.WIDTH(NCOL)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp_col_sense),
    .q     (col_sync_s)
  );

  // Scan-result decode; the current row's sample is folded in so the
  // result is complete on the last dwell cycle of row 0.
  always_comb begin
    dwell_last_s = (dwell_q == DWELL_LAST);
    scan_done_s  = dwell_last_s && (ridx_q == 2'd0);
    scan_s       = acc_q;
    scan_s[ridx_q] = col_sync_s;
    single_s     = ($countones(scan_s) == 32'd1);
    srow_s       = 4'b0000;
    scol_s       = 3'b000;
    for (int r = 0; r < NROW; r++) begin
      srow_s[r] = |scan_s[r];
      scol_s    = scol_s | scan_s[r];
    end
    same_key_s = single_s && prev_valid_q && (srow_s == prev_row_q) && (scol_s == prev_col_q);
    deb_inc_s  = (deb_q == DEB_MAX) ? DEB_MAX : deb_q + DW'(1);
  end

  // Row strobe sequencing and per-row column sampling.
  always_comb begin
    dwell_d   = dwell_q;
    ridx_d    = ridx_q;
    row_drv_d = row_drv_q;
    acc_d     = acc_q;
    if (dwell_last_s) begin
      dwell_d        = '0;
      acc_d[ridx_q]  = col_sync_s;
      ridx_d         = ridx_q - 2'd1;
      row_drv_d      = 4'b0001 << ridx_d;
    end else begin
      dwell_d = dwell_q + CW'(1);
    end
  end

  // Debounce FSM and output next-state, evaluated once per full scan.
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    deb_next_s   = '0;
    prev_valid_d = prev_valid_q;
    prev_row_d   = prev_row_q;
    prev_col_d   = prev_col_q;
    row_d        = row_q;
    col_d        = col_q;
    valid_d      = valid_q;
    code_d       = code_q;
    pulse_d      = 1'b0;
    if (scan_done_s) begin
      prev_valid_d = single_s;
      prev_row_d   = srow_s;
      prev_col_d   = scol_s;
      case (state_q)
        ST_RELEASED: begin
          if (same_key_s) begin
            deb_next_s = deb_inc_s;
          end else if (single_s) begin
            deb_next_s = DW'(1);
          end else begin
            deb_next_s = '0;
          end
          if (deb_next_s == DEB_MAX) begin
            state_d = ST_PRESSED;
            deb_d   = '0;
            row_d   = srow_s;
            col_d   = scol_s;
            valid_d = 1'b1;
            code_d  = kp_encode(srow_s, scol_s);
            pulse_d = 1'b1;
          end else begin
            deb_d = deb_next_s;
          end
        end
        ST_PRESSED: begin
          // Any single key, even a different one, holds off release.
          deb_next_s = single_s ? '0 : deb_inc_s;
          if (deb_next_s == DEB_MAX) begin
            state_d = ST_RELEASED;
            deb_d   = '0;
            row_d   = 4'b0000;
            col_d   = 3'b000;
            valid_d = 1'b0;
            code_d  = KEY_NONE;
          end else begin
            deb_d = deb_next_s;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          deb_d   = '0;
          row_d   = 4'b0000;
          col_d   = 3'b000;
          valid_d = 1'b0;
          code_d  = KEY_NONE;
        end
      endcase
    end else begin
      pulse_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_q      <= '0;
      ridx_q       <= 2'd3;
      row_drv_q    <= 4'b1000;
      acc_q        <= '0;
      state_q      <= ST_RELEASED;
      deb_q        <= '0;
      prev_valid_q <= 1'b0;
      prev_row_q   <= 4'b0000;
      prev_col_q   <= 3'b000;
      row_q        <= 4'b0000;
      col_q        <= 3'b000;
      valid_q      <= 1'b0;
      code_q       <= KEY_NONE;
      pulse_q      <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      ridx_q       <= ridx_d;
      row_drv_q    <= row_drv_d;
      acc_q        <= acc_d;
      state_q      <= state_d;
      deb_q        <= deb_d;
      prev_valid_q <= prev_valid_d;
      prev_row_q   <= prev_row_d;
      prev_col_q   <= prev_col_d;
      row_q        <= row_d;
      col_q        <= col_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      pulse_q      <= pulse_d;
    end
  end

  assign kp_row_drv = row_drv_q;
  assign row        = row_q;
  assign col        = col_q;
  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_pulse  = pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model drives the sense lines and a
// scan-level reference model predicts every output on every cycle.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;
  localparam int LAT  = (DB + 1) * SCAN + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] kp_row_drv;
  logic [2:0] kp_col_sense;
  logic [3:0] row;
  logic [2:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_pulse;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kp_row_drv   (kp_row_drv),
    .kp_col_sense (kp_col_sense),
    .row          (row),
    .col          (col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_pulse    (key_pulse)
  );

  always #5 clk = ~clk;

  logic [2:0] keys [4];
  int key_tab [4][3];
  int n_checks = 0;
  int n_pass = 0;
  int pulse_cnt = 0;

  // Physical matrix: the driven row connects its pressed keys to the columns.
  always_comb begin
    kp_col_sense = 3'b000;
    for (int r = 0; r < 4; r++)
      if (kp_row_drv[r]) kp_col_sense = kp_col_sense | keys[r];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: scan-level view with cycle timing from plain arithmetic.
  int         m_n = 0;
  logic [2:0] m_samp [4];
  bit         m_pressed = 0;
  int         m_cnt = 0;
  int         m_prev = -1;
  logic [3:0] e_drv = 4'b1000;
  logic [3:0] e_row = 4'b0000;
  logic [2:0] e_col = 3'b000;
  logic       e_valid = 1'b0;
  logic [3:0] e_code = 4'd15;
  logic       e_pulse = 1'b0;

  task automatic model_scan();
    int hits, hr, hc, key;
    hits = 0; hr = 0; hc = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (m_samp[r][c]) begin hits++; hr = r; hc = c; end
    key = (hits == 1) ? key_tab[hr][hc] : -1;
    if (!m_pressed) begin
      if (key >= 0 && key == m_prev) m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
      else m_cnt = (key >= 0) ? 1 : 0;
      if (m_cnt >= DB) begin
        m_pressed = 1; m_cnt = 0;
        e_valid = 1'b1; e_row = 4'b0001 << hr; e_col = 3'b001 << hc;
        e_code = 4'(key); e_pulse = 1'b1;
      end
    end else begin
      m_cnt = (key < 0) ? m_cnt + 1 : 0;
      if (m_cnt >= DB) begin
        m_pressed = 0; m_cnt = 0;
        e_valid = 1'b0; e_row = 4'b0000; e_col = 3'b000; e_code = 4'd15;
      end
    end
    m_prev = key;
  endtask

  task automatic model_step();
    int r;
    if (!rst_n) begin
      m_n = 0; m_pressed = 0; m_cnt = 0; m_prev = -1;
      for (int i = 0; i < 4; i++) m_samp[i] = 3'b000;
      e_drv = 4'b1000; e_row = 4'b0000; e_col = 3'b000;
      e_valid = 1'b0; e_code = 4'd15; e_pulse = 1'b0;
    end else begin
      e_pulse = 1'b0;
      r = 3 - (m_n / SD) % 4;
      // Column value seen at dwell offset 1 is what reaches the sample point.
      if (m_n % SD == 1) m_samp[r] = keys[r];
      if (m_n % SCAN == SCAN - 1) model_scan();
      e_drv = 4'b0001 << (3 - ((m_n + 1) / SD) % 4);
      m_n++;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("outputs{drv,row,col,valid,code,pulse}",
        int'({kp_row_drv, row, col, key_valid, key_code, key_pulse}),
        int'({e_drv, e_row, e_col, e_valid, e_code, e_pulse}));
    if (key_pulse) pulse_cnt++;
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
  endtask

  task automatic set_key(input int code, input logic on);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_tab[r][c] == code) keys[r][c] = on;
  endtask

  task automatic wait_valid(input logic want, input int budget, input string name);
    int i;
    i = 0;
    while (key_valid !== want && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(key_valid === want), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] walk [4];
    int p0;
    walk[0] = 4'b1000; walk[1] = 4'b0100; walk[2] = 4'b0010; walk[3] = 4'b0001;
    key_tab[3] = '{3, 2, 1};
    key_tab[2] = '{6, 5, 4};
    key_tab[1] = '{9, 8, 7};
    key_tab[0] = '{11, 0, 10};
    clear_keys();
    rst_n = 1'b0;

    // 1) reset values and row walk
    cycles(3);
    chk("rst_drv", kp_row_drv, 4'b1000);
    chk("rst_row", row, 4'b0000);
    chk("rst_col", col, 3'b000);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'd15);
    chk("rst_pulse", key_pulse, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("row_walk", kp_row_drv, walk[((i + 1) / SD) % 4]);
    end

    // 2) steady '5'
    p0 = pulse_cnt;
    set_key(5, 1'b1);
    wait_valid(1'b1, LAT, "press5_latency");
    chk("press5_row", row, 4'b0100);
    chk("press5_col", col, 3'b010);
    chk("press5_code", key_code, 4'd5);
    cycles(2 * SCAN);
    chk("press5_pulses", pulse_cnt - p0, 1);
    clear_keys();
    wait_valid(1'b0, LAT, "rel5_latency");
    chk("rel5_row", row, 4'b0000);
    chk("rel5_col", col, 3'b000);
    chk("rel5_code", key_code, 4'd15);
    cycles(2 * SCAN);

    // 3) bouncing '1' then held
    p0 = pulse_cnt;
    set_key(1, 1'b1); cycles(SCAN);
    clear_keys();     cycles(SCAN);
    set_key(1, 1'b1); cycles(SCAN);
    chk("bounce_quiet_valid", key_valid, 1'b0);
    chk("bounce_quiet_pulses", pulse_cnt - p0, 0);
    wait_valid(1'b1, LAT, "bounce1_accept");
    chk("bounce1_row", row, 4'b1000);
    chk("bounce1_col", col, 3'b100);
    cycles(2 * SCAN);
    chk("bounce1_pulses", pulse_cnt - p0, 1);
    clear_keys();
    wait_valid(1'b0, LAT, "bounce1_release");
    cycles(SCAN);

    // 4) ghost: '1' and '5' together, then '5' released
    p0 = pulse_cnt;
    set_key(1, 1'b1); set_key(5, 1'b1);
    cycles(5 * SCAN);
    chk("ghost_row", row, 4'b0000);
    chk("ghost_pulses", pulse_cnt - p0, 0);
    set_key(5, 1'b0);
    wait_valid(1'b1, LAT, "ghost_then1");
    chk("ghost_then1_code", key_code, 4'd1);
    clear_keys();
    wait_valid(1'b0, LAT, "ghost_release");
    cycles(SCAN);

    // 5) '#' accepted, switched to '2': latched key holds until released
    p0 = pulse_cnt;
    set_key(11, 1'b1);
    wait_valid(1'b1, LAT, "hash_accept");
    chk("hash_row", row, 4'b0001);
    chk("hash_col", col, 3'b001);
    chk("hash_code", key_code, 4'd11);
    clear_keys(); set_key(2, 1'b1);
    cycles(4 * SCAN);
    chk("switch_holds_hash", key_code, 4'd11);
    clear_keys();
    wait_valid(1'b0, LAT, "hash_release");
    chk("hash_release_code", key_code, 4'd15);
    set_key(2, 1'b1);
    wait_valid(1'b1, LAT, "two_accept");
    chk("two_code", key_code, 4'd2);
    chk("two_rowcol", int'({row, col}), int'({4'b1000, 3'b010}));
    cycles(SCAN);
    chk("switch_pulses", pulse_cnt - p0, 2);
    clear_keys();
    wait_valid(1'b0, LAT, "two_release");
    cycles(SCAN);

    // 6) reset while '0' held
    set_key(0, 1'b1);
    wait_valid(1'b1, LAT, "zero_accept");
    chk("zero_code", key_code, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rowcol", int'({row, col, key_valid}), 0);
    chk("midrst_code", key_code, 4'd15);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    cycles(2 * SCAN - 1);
    chk("rearm_not_early", key_valid, 1'b0);
    cycles(1);
    chk("rearm_accept", key_valid, 1'b1);
    chk("rearm_code", key_code, 4'd0);
    chk("rearm_pulses", pulse_cnt - p0, 1);
    clear_keys();
    wait_valid(1'b0, LAT, "zero_release");

    // randomized presses, ghosts and glitches against the model
    for (int it = 0; it < 40; it++) begin
      int k;
      clear_keys();
      k = $urandom_range(0, 9);
      if (k < 6) set_key($urandom_range(0, 11), 1'b1);
      else if (k < 8) begin
        set_key($urandom_range(0, 11), 1'b1);
        set_key($urandom_range(0, 11), 1'b1);
      end
      cycles($urandom_range(8, 3 * SCAN + 10));
    end
    clear_keys();
    cycles(4 * SCAN);
    chk("final_idle", key_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
